// File: rtl/iq_sym_serializer_if.sv
// Serial bit-stream handshake between the symbol serializer and the downstream bit sink.
interface iq_sym_serializer_if;
  logic bit_valid;
  logic bit_ready;
  logic bit_data;
  logic bit_first;

  modport master (output bit_valid, output bit_data, output bit_first, input bit_ready);
  modport slave  (input bit_valid, input bit_data, input bit_first, output bit_ready);
endinterface

// File: rtl/iq_sym_serializer.sv
// I/Q symbol serializer: optional per-axis Gray decode, DEPTH-entry symbol FIFO,
// MSB-first valid/ready bit stream with per-symbol first-bit framing and sticky overflow.
module iq_sym_serializer #(
  parameter int BPA      = 1,
  parameter int DEPTH    = 4,
  parameter bit GRAY_DEC = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sym_valid,
  input  logic [BPA-1:0]           sym_i,
  input  logic [BPA-1:0]           sym_q,
  input  logic                     iq_order,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  iq_sym_serializer_if.master      ser
);

  localparam int SW = 2 * BPA;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(SW);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [SW-1:0]     shreg;
  logic [CW-1:0]     bitcnt;
  logic              first_q;
  logic [BPA-1:0]    dec_i, dec_q;
  logic [SW-1:0]     wr_word;
  logic              clear, full, not_empty, push, drop, handshake, last_bit, pop;

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [BPA-1:0] gray2bin(input logic [BPA-1:0] g);
    logic [BPA-1:0] b;
    b = g;
    for (int k = BPA - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  assign dec_i     = GRAY_DEC ? gray2bin(sym_i) : sym_i;
  assign dec_q     = GRAY_DEC ? gray2bin(sym_q) : sym_q;
  assign wr_word   = iq_order ? {dec_q, dec_i} : {dec_i, dec_q};

  assign clear     = rst | flush;
  assign full      = (fill == FW'(DEPTH));
  assign not_empty = (fill != '0);
  // A full FIFO drops the incoming symbol even if a pop frees a slot this cycle.
  assign push      = sym_valid & ~full;
  assign drop      = sym_valid & full;
  assign handshake = (state == SHIFT) & ser.bit_ready;
  assign last_bit  = (bitcnt == CW'(SW - 1));

  assign ser.bit_valid = (state == SHIFT);
  assign ser.bit_data  = shreg[SW-1];
  assign ser.bit_first = first_q;

  // Next-state and pop decision; back-to-back symbols reload on the last-bit handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (handshake && last_bit) begin
          if (not_empty) pop = 1'b1;
          else           state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset and flush both return to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; fill and pointers define what is valid.
    if (push && !clear) mem[wr_ptr] <= wr_word;
  end

  // Pointers, occupancy, shifter, bit counter, framing flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      first_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase

      if (pop) begin
        shreg   <= mem[rd_ptr];
        bitcnt  <= '0;
        first_q <= 1'b1;
      end else if (handshake) begin
        shreg   <= {shreg[SW-2:0], 1'b0};
        bitcnt  <= bitcnt + CW'(1);
        first_q <= 1'b0;
      end

      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iq_sym_serializer.sv
// Self-checking bench for iq_sym_serializer (BPA=2, DEPTH=4, GRAY_DEC=1) against a
// queue-based symbol/bit model, plus directed scenarios with literal expectations.
module tb_iq_sym_serializer;

  localparam int BPA   = 2;
  localparam int DEPTH = 4;
  localparam int SW    = 2 * BPA;

  logic           clk = 1'b0;
  logic           rst, sym_valid, iq_order, flush;
  logic [BPA-1:0] sym_i, sym_q;
  logic [2:0]     fill;
  logic           overflow;

  iq_sym_serializer_if ser ();

  iq_sym_serializer #(.BPA(BPA), .DEPTH(DEPTH), .GRAY_DEC(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym_i     (sym_i),
    .sym_q     (sym_q),
    .iq_order  (iq_order),
    .flush     (flush),
    .fill      (fill),
    .overflow  (overflow),
    .ser       (ser)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: symbols waiting in the FIFO, bits remaining of the symbol on the wire.
  logic [SW-1:0] m_fifo[$];
  bit            m_bits[$];
  bit            m_first;
  bit            m_ovf;

  // Observed handshakes.
  bit obs_bit[$];
  bit obs_first[$];
  int obs_cyc[$];

  bit   hold;
  logic hold_data, hold_first;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] model_word(input logic [BPA-1:0] i, input logic [BPA-1:0] q,
                                               input logic o);
    logic [BPA-1:0] bi, bq;
    bi = i;
    bq = q;
    for (int s = 1; s < BPA; s++) begin
      bi = bi ^ (i >> s);
      bq = bq ^ (q >> s);
    end
    return o ? {bq, bi} : {bi, bq};
  endfunction

  task automatic model_edge();
    int            pre;
    logic [SW-1:0] w;
    if (rst || flush) begin
      m_fifo.delete();
      m_bits.delete();
      m_first = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      pre = m_fifo.size();
      if (m_bits.size() > 0 && ser.bit_ready) begin
        void'(m_bits.pop_front());
        m_first = 1'b0;
      end
      if (m_bits.size() == 0 && pre > 0) begin
        w = m_fifo.pop_front();
        for (int k = SW - 1; k >= 0; k--) m_bits.push_back(w[k]);
        m_first = 1'b1;
      end
      if (sym_valid) begin
        if (pre < DEPTH) m_fifo.push_back(model_word(sym_i, sym_q, iq_order));
        else             m_ovf = 1'b1;
      end
    end
  endtask

  // One clock: log handshake, advance model at the edge, compare at the falling edge.
  task automatic step();
    if (ser.bit_valid && ser.bit_ready) begin
      obs_bit.push_back(ser.bit_data);
      obs_first.push_back(ser.bit_first);
      obs_cyc.push_back(cyc);
    end
    hold       = ser.bit_valid && !ser.bit_ready && !rst && !flush;
    hold_data  = ser.bit_data;
    hold_first = ser.bit_first;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check("bit_valid", ser.bit_valid, int'(m_bits.size() > 0));
    if (m_bits.size() > 0) begin
      check("bit_data", ser.bit_data, m_bits[0]);
      check("bit_first", ser.bit_first, m_first);
    end else begin
      check("bit_first_idle", ser.bit_first, 0);
    end
    check("fill", fill, m_fifo.size());
    check("overflow", overflow, m_ovf);
    if (hold) begin
      check("hold_data", ser.bit_data, hold_data);
      check("hold_first", ser.bit_first, hold_first);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic strobe(input logic [BPA-1:0] i, input logic [BPA-1:0] q, input logic o);
    sym_valid = 1'b1;
    sym_i     = i;
    sym_q     = q;
    iq_order  = o;
    step();
    sym_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_bit.delete();
    obs_first.delete();
    obs_cyc.delete();
  endtask

  initial begin
    logic [7:0]    exp_bits;
    logic [7:0]    exp_first;
    logic [SW-1:0] words[$];
    logic [SW-1:0] w;
    logic [BPA-1:0] ri, rq;
    logic          ro;
    int            c0, n, idx, firsts;

    rst = 1'b1; flush = 1'b0; sym_valid = 1'b0;
    sym_i = '0; sym_q = '0; iq_order = 1'b0;
    ser.bit_ready = 1'b0;
    run(2);
    rst = 1'b0;

    // Reset state.
    check("reset_valid", ser.bit_valid, 0);
    check("reset_data", ser.bit_data, 0);
    check("reset_first", ser.bit_first, 0);
    check("reset_fill", fill, 0);
    check("reset_overflow", overflow, 0);

    // Pin the model's Gray decode and packing.
    check("model_pin_iq", model_word(2'b10, 2'b01, 1'b0), 4'b1101);
    check("model_pin_qi", model_word(2'b10, 2'b01, 1'b1), 4'b0111);

    // Two back-to-back symbols with ready high: exact bits, framing, latency, no bubble.
    ser.bit_ready = 1'b1;
    clear_obs();
    c0 = cyc;
    strobe(2'b10, 2'b01, 1'b0);
    strobe(2'b10, 2'b01, 1'b1);
    run(12);
    exp_bits  = 8'b1101_0111;
    exp_first = 8'b1000_1000;
    check("t1_count", obs_bit.size(), 8);
    if (obs_bit.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check("t1_bit", obs_bit[k], exp_bits[7-k]);
        check("t1_first", obs_first[k], exp_first[7-k]);
      end
      check("t1_latency", obs_cyc[0], c0 + 2);
      check("t1_no_bubble", obs_cyc[7] - obs_cyc[0], 7);
    end

    // Fill to capacity with ready low, overflow on the sixth strobe, then drain.
    ser.bit_ready = 1'b0;
    words.delete();
    for (int k = 0; k < 6; k++) begin
      ri = BPA'($urandom); rq = BPA'($urandom); ro = 1'($urandom);
      words.push_back(model_word(ri, rq, ro));
      strobe(ri, rq, ro);
      if (k == 4) begin
        check("t3_fill_full", fill, 4);
        check("t3_no_ovf_yet", overflow, 0);
      end
      if (k == 5) begin
        check("t3_fill_still_full", fill, 4);
        check("t3_overflow", overflow, 1);
      end
    end
    clear_obs();
    ser.bit_ready = 1'b1;
    run(30);
    check("t3_drain_bits", obs_bit.size(), 5 * SW);
    firsts = 0;
    foreach (obs_first[k]) firsts += obs_first[k];
    check("t3_drain_symbols", firsts, 5);
    if (obs_bit.size() == 5 * SW) begin
      idx = 0;
      for (int s = 0; s < 5; s++) begin
        w = words[s];
        for (int b = SW - 1; b >= 0; b--) begin
          check("t3_order", obs_bit[idx], w[b]);
          idx++;
        end
      end
    end
    check("t3_overflow_sticky", overflow, 1);

    // Flush mid-symbol with two symbols queued.
    ser.bit_ready = 1'b0;
    repeat (3) strobe(BPA'($urandom), BPA'($urandom), 1'($urandom));
    check("t5_fill_before", fill, 2);
    ser.bit_ready = 1'b1;
    step();
    ser.bit_ready = 1'b0;
    step();
    check("t5_mid_valid", ser.bit_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_flush_valid", ser.bit_valid, 0);
    check("t5_flush_fill", fill, 0);
    check("t5_flush_overflow", overflow, 0);
    strobe(2'b11, 2'b00, 1'b0);
    ser.bit_ready = 1'b1;
    n = 0;
    while (!ser.bit_valid && n < 5) begin
      step();
      n++;
    end
    check("t5_restart_valid", ser.bit_valid, 1);
    check("t5_restart_first", ser.bit_first, 1);
    run(8);

    // Reset together with a strobe and flush: everything cleared, strobe ignored.
    ser.bit_ready = 1'b0;
    repeat (2) strobe(BPA'($urandom), BPA'($urandom), 1'($urandom));
    rst = 1'b1; flush = 1'b1; sym_valid = 1'b1; sym_i = 2'b01; sym_q = 2'b10;
    step();
    rst = 1'b0; flush = 1'b0; sym_valid = 1'b0;
    check("t6_valid", ser.bit_valid, 0);
    check("t6_data", ser.bit_data, 0);
    check("t6_first", ser.bit_first, 0);
    check("t6_fill", fill, 0);
    check("t6_overflow", overflow, 0);
    ser.bit_ready = 1'b1;
    run(4);
    check("t6_strobe_ignored", ser.bit_valid, 0);

    // Randomized traffic with toggling ready, occasional flush and reset.
    repeat (3000) begin
      sym_valid     = ($urandom % 5) == 0;
      sym_i         = BPA'($urandom);
      sym_q         = BPA'($urandom);
      iq_order      = 1'($urandom);
      ser.bit_ready = ($urandom % 4) != 0;
      flush         = ($urandom % 250) == 0;
      rst           = ($urandom % 700) == 0;
      step();
    end
    rst = 1'b0; flush = 1'b0; sym_valid = 1'b0; ser.bit_ready = 1'b1;

    // Sustained full-rate input: one symbol every SW cycles with ready high.
    repeat (40) begin
      sym_valid = 1'b1;
      sym_i = BPA'($urandom); sym_q = BPA'($urandom); iq_order = 1'($urandom);
      step();
      sym_valid = 1'b0;
      run(SW - 1);
    end
    run(20);
    check("final_idle", ser.bit_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
